// File: rtl/blockram_fifo_controller_if.sv
// Producer/consumer handshake bundle for blockram_fifo_controller.
// master = producer/consumer side, slave = controller side.
interface blockram_fifo_controller_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  request_valid_in;
  logic [DATA_WIDTH-1:0] request_data_in;
  logic                  request_ready_out;
  logic                  issue_valid_out;
  logic [DATA_WIDTH-1:0] issue_data_out;
  logic                  issue_ack_in;

  modport master (
    output request_valid_in,
    output request_data_in,
    output issue_ack_in,
    input  request_ready_out,
    input  issue_valid_out,
    input  issue_data_out
  );

  modport slave (
    input  request_valid_in,
    input  request_data_in,
    input  issue_ack_in,
    output request_ready_out,
    output issue_valid_out,
    output issue_data_out
  );
endinterface

// File: rtl/blockram_fifo_controller.sv
// Valid/ready FIFO front-end for dual_port_blockram with a
// prefetching output buffer hiding the one-cycle read latency.
module blockram_fifo_controller #(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int BYTE_LEN_IN_BITS           = 8,
  parameter int WRITE_MASK_LEN             =
    SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS,
  parameter int OUT_DEPTH                  = 4
) (
  input  logic clk_in,
  input  logic reset_in,

  blockram_fifo_controller_if.slave bus,

  output logic                                  write_port_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]             write_port_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]      write_port_access_set_addr_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_port_data_out,

  output logic                                  read_port_access_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]      read_port_access_set_addr_out,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_port_data_in,
  input  logic                                  read_port_valid_in,

  output logic [$clog2(NUM_SET+OUT_DEPTH+1)-1:0] occupancy_out,
  output logic                                   error_out
);

  localparam int W   = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int PW  = SET_PTR_WIDTH_IN_BITS;
  localparam int CW  = PW + 1;
  localparam int BIW = $clog2(OUT_DEPTH);
  localparam int BCW = $clog2(OUT_DEPTH + 1);
  localparam int OW  = $clog2(NUM_SET + OUT_DEPTH + 1);

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  ram_count;
  logic [1:0]     inflight;
  logic [BCW-1:0] buf_count;
  logic [BIW-1:0] head;
  logic [BIW-1:0] tail;
  logic [W-1:0]   buf_q [OUT_DEPTH];
  logic           ret_q;
  logic           error_q;
  logic [OW-1:0]  occ_q;

  logic           push;
  logic           fetch;
  logic           ack;
  logic [BCW:0]   used;
  logic [CW-1:0]  ram_n;
  logic [1:0]     inflight_n;
  logic [BCW-1:0] buf_n;
  logic [OW-1:0]  occ_n;

  assign bus.request_ready_out = (ram_count != CW'(NUM_SET));
  assign bus.issue_valid_out   = (buf_count != '0);
  assign bus.issue_data_out    = buf_q[head];

  assign occupancy_out = occ_q;
  assign error_out     = error_q;

  // ram_count is registered, so it never counts a push made this cycle.
  always_comb begin
    push       = 1'b0;
    fetch      = 1'b0;
    ack        = 1'b0;
    used       = '0;
    push       = bus.request_valid_in & bus.request_ready_out & reset_in;
    used       = (BCW+1)'(buf_count) + (BCW+1)'(inflight);
    fetch      = reset_in & (ram_count != '0)
               & (used < (BCW+1)'(OUT_DEPTH));
    ack        = bus.issue_ack_in & bus.issue_valid_out;
    ram_n      = ram_count + CW'(push) - CW'(fetch);
    inflight_n = inflight + 2'(fetch) - 2'(ret_q);
    buf_n      = buf_count + BCW'(ret_q) - BCW'(ack);
    occ_n      = OW'(ram_n) + OW'(inflight_n) + OW'(buf_n);
  end

  always_comb begin
    write_port_access_en_out       = 1'b0;
    write_port_write_en_out        = '0;
    write_port_access_set_addr_out = '0;
    write_port_data_out            = '0;
    read_port_access_en_out        = 1'b0;
    read_port_access_set_addr_out  = '0;
    if (push) begin
      write_port_access_en_out       = 1'b1;
      write_port_write_en_out        = '1;
      write_port_access_set_addr_out = wr_ptr;
      write_port_data_out            = bus.request_data_in;
    end
    if (fetch) begin
      read_port_access_en_out       = 1'b1;
      read_port_access_set_addr_out = rd_ptr;
    end
  end

  // Clearing ret_q drops a read that returns in the cycle after reset.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      inflight  <= '0;
      buf_count <= '0;
      head      <= '0;
      tail      <= '0;
      ret_q     <= 1'b0;
      error_q   <= 1'b0;
      occ_q     <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      wr_ptr    <= wr_ptr + PW'(push);
      rd_ptr    <= rd_ptr + PW'(fetch);
      ram_count <= ram_n;
      inflight  <= inflight_n;
      buf_count <= buf_n;
      head      <= head + BIW'(ack);
      tail      <= tail + BIW'(ret_q);
      ret_q     <= fetch;
      occ_q     <= occ_n;
      if (ret_q) begin
        buf_q[tail] <= read_port_data_in;
      end
      if (ret_q && !read_port_valid_in) begin
        error_q <= 1'b1;
      end
    end
  end

endmodule
